// File: rtl/ripple_count_monitor_pkg.sv
// Shared constants and state encoding for the ripple counter monitor.
package ripple_count_monitor_pkg;

  localparam int unsigned CNT_W             = 4;
  localparam int unsigned STABLE_CYCLES_DEF = 2;
  localparam int unsigned MAX_STEP_DEF      = 3;

  typedef enum logic [1:0] {
    S_INIT  = 2'd0,
    S_TRACK = 2'd1,
    S_CLR   = 2'd2
  } state_e;

endpackage

// File: rtl/ripple_count_monitor_sync_2ff.sv
// Two-flop synchronizer with a programmable synchronous reset value.
module sync_2ff #(
  parameter int unsigned      WIDTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] s1_q;
  logic [WIDTH-1:0] s2_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q <= RESET_VAL;
      s2_q <= RESET_VAL;
    end else begin
      s1_q <= d;
      s2_q <= s1_q;
    end
  end

  assign q = s2_q;

endmodule

// File: rtl/ripple_count_monitor.sv
// Samples the ripple counter into Clk, filters transients, tracks a wide down
// count across borrows and flags illegal jumps.
module ripple_count_monitor
  import ripple_count_monitor_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = STABLE_CYCLES_DEF,
  parameter int unsigned MAX_STEP      = MAX_STEP_DEF,
  parameter int unsigned EXT_W         = 8
) (
  input  logic             Clk,
  input  logic             Clr,
  input  logic [CNT_W-1:0] count_in,
  input  logic             cnt_clr_n,
  output logic [CNT_W-1:0] count_q,
  output logic [EXT_W-1:0] ext_count,
  output logic             valid,
  output logic             step_pulse,
  output logic             wrap_pulse,
  output logic             err_pulse,
  output logic             err_sticky
);

  localparam int unsigned      HI_W       = EXT_W - CNT_W;
  localparam logic [CNT_W-1:0] RUN_MAX    = '1;
  localparam logic [CNT_W-1:0] ACCEPT_RUN = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] MAX_D      = CNT_W'(MAX_STEP);
  localparam logic [1:0]       FILL_DONE  = 2'd3;

  logic [CNT_W-1:0] cnt_s2;
  logic             clr_n_s2;

  state_e           state_q, state_d;
  logic [1:0]       fill_q, fill_d;
  logic [CNT_W-1:0] cand_q, cand_d;
  logic [CNT_W-1:0] run_q, run_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [HI_W-1:0]  hi_q, hi_d;
  logic             valid_q, valid_d;
  logic             step_q, step_d;
  logic             wrap_q, wrap_d;
  logic             err_q, err_d;
  logic             sticky_q, sticky_d;

  logic             primed;
  logic             accept;
  logic [CNT_W-1:0] diff;

  sync_2ff #(
    .WIDTH    (CNT_W),
    .RESET_VAL({CNT_W{1'b0}})
  ) u_cnt_sync (
    .clk(Clk),
    .rst(Clr),
    .d  (count_in),
    .q  (cnt_s2)
  );

  sync_2ff #(
    .WIDTH    (1),
    .RESET_VAL(1'b1)
  ) u_clr_sync (
    .clk(Clk),
    .rst(Clr),
    .d  (cnt_clr_n),
    .q  (clr_n_s2)
  );

  always_comb begin
    fill_d   = (fill_q == FILL_DONE) ? fill_q : fill_q + 2'd1;
    // Synchronizer and candidate flops hold reset zeros, not bus samples,
    // until the first real sample has reached both of them.
    primed   = (fill_q == FILL_DONE);
    cand_d   = cnt_s2;
    run_d    = run_q;
    if (!primed || cnt_s2 != cand_q) begin
      run_d = '0;
    end else if (run_q != RUN_MAX) begin
      run_d = run_q + 1'b1;
    end
    accept   = primed && (cnt_s2 == cand_q) && (run_q == ACCEPT_RUN);
    diff     = cnt_q - cnt_s2;

    state_d  = state_q;
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    valid_d  = valid_q;
    step_d   = 1'b0;
    wrap_d   = 1'b0;
    err_d    = 1'b0;
    sticky_d = sticky_q;

    if (!clr_n_s2) begin
      state_d = S_CLR;
      valid_d = 1'b0;
      cnt_d   = '0;
      hi_d    = '0;
      run_d   = '0;
    end else begin
      unique case (state_q)
        S_INIT, S_CLR: begin
          state_d = S_INIT;
          if (accept) begin
            cnt_d   = cnt_s2;
            hi_d    = '0;
            valid_d = 1'b1;
            state_d = S_TRACK;
          end
        end
        S_TRACK: begin
          if (accept && diff != '0) begin
            if (diff <= MAX_D) begin
              cnt_d  = cnt_s2;
              step_d = 1'b1;
              if (cnt_s2 > cnt_q) begin
                wrap_d = 1'b1;
                hi_d   = hi_q - HI_W'(1);
              end
            end else begin
              err_d    = 1'b1;
              sticky_d = 1'b1;
              state_d  = S_INIT;
            end
          end
        end
        default: state_d = S_INIT;
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (Clr) begin
      state_q  <= S_INIT;
      fill_q   <= '0;
      cand_q   <= '0;
      run_q    <= '0;
      cnt_q    <= '0;
      hi_q     <= '0;
      valid_q  <= 1'b0;
      step_q   <= 1'b0;
      wrap_q   <= 1'b0;
      err_q    <= 1'b0;
      sticky_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      fill_q   <= fill_d;
      cand_q   <= cand_d;
      run_q    <= run_d;
      cnt_q    <= cnt_d;
      hi_q     <= hi_d;
      valid_q  <= valid_d;
      step_q   <= step_d;
      wrap_q   <= wrap_d;
      err_q    <= err_d;
      sticky_q <= sticky_d;
    end
  end

  assign count_q    = cnt_q;
  assign ext_count  = {hi_q, cnt_q};
  assign valid      = valid_q;
  assign step_pulse = step_q;
  assign wrap_pulse = wrap_q;
  assign err_pulse  = err_q;
  assign err_sticky = sticky_q;

endmodule

// File: tb/tb_ripple_count_monitor.sv
// Bench for ripple_count_monitor: directed segment table, hand-written corner
// sequences, and random bus activity checked against a sample-history model.
module tb_ripple_count_monitor;

  localparam int STABLE  = 2;
  localparam int MAXS    = 3;
  localparam int EXT_W   = 8;
  localparam int HI_MASK = (1 << (EXT_W - 4)) - 1;

  logic             Clk = 1'b0;
  logic             Clr;
  logic [3:0]       count_in;
  logic             cnt_clr_n;
  logic [3:0]       count_q;
  logic [EXT_W-1:0] ext_count;
  logic             valid;
  logic             step_pulse;
  logic             wrap_pulse;
  logic             err_pulse;
  logic             err_sticky;

  ripple_count_monitor #(
    .STABLE_CYCLES(STABLE),
    .MAX_STEP     (MAXS),
    .EXT_W        (EXT_W)
  ) dut (
    .Clk       (Clk),
    .Clr       (Clr),
    .count_in  (count_in),
    .cnt_clr_n (cnt_clr_n),
    .count_q   (count_q),
    .ext_count (ext_count),
    .valid     (valid),
    .step_pulse(step_pulse),
    .wrap_pulse(wrap_pulse),
    .err_pulse (err_pulse),
    .err_sticky(err_sticky)
  );

  always #5 Clk = ~Clk;

  int n_checks = 0;
  int n_errors = 0;
  int n_step, n_wrap, n_err;

  // Reference model: bus samples since reset plus the abstract tracker state.
  bit model_en = 1'b0;
  int samples[$];
  int m_cnt, m_hi, m_valid, m_acq, m_sticky, m_step, m_wrap, m_err;

  typedef struct {
    logic [3:0] val;
    int         hold;
    logic [3:0] cnt;
    logic [7:0] ext;
    logic       vld;
    int         steps;
    int         wraps;
    int         errs;
    logic       sticky;
  } vec_t;

  vec_t vecs[22];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic model_edge();
    int  m, base, v, d;
    bit  acc;
    samples.push_back(int'(count_in));
    m      = samples.size();
    m_step = 0;
    m_wrap = 0;
    m_err  = 0;
    acc    = 1'b0;
    // Accept when the value has been seen in exactly STABLE+1 consecutive
    // samples, the last of which was taken two edges ago.
    if (m >= STABLE + 3) begin
      base = m - 3 - STABLE;
      acc  = 1'b1;
      for (int j = base; j <= m - 3; j++) if (samples[j] != samples[base]) acc = 1'b0;
      if (base > 0 && samples[base-1] == samples[base]) acc = 1'b0;
    end
    if (acc) begin
      v = samples[m-3];
      if (m_acq == 0) begin
        m_cnt   = v;
        m_hi    = 0;
        m_valid = 1;
        m_acq   = 1;
      end else begin
        d = (m_cnt - v) & 15;
        if (d != 0 && d <= MAXS) begin
          if (v > m_cnt) begin
            m_wrap = 1;
            m_hi   = (m_hi - 1) & HI_MASK;
          end
          m_cnt  = v;
          m_step = 1;
        end else if (d > MAXS) begin
          m_err    = 1;
          m_sticky = 1;
          m_acq    = 0;
        end
      end
    end
  endtask

  task automatic tick(input int n);
    logic [12:0] got, exp;
    for (int i = 0; i < n; i++) begin
      @(posedge Clk);
      if (model_en) model_edge();
      #1;
      if (step_pulse) n_step++;
      if (wrap_pulse) n_wrap++;
      if (err_pulse) n_err++;
      if (model_en) begin
        got = {ext_count, valid, step_pulse, wrap_pulse, err_pulse, err_sticky};
        exp = {4'(m_hi), 4'(m_cnt), 1'(m_valid), 1'(m_step), 1'(m_wrap), 1'(m_err),
               1'(m_sticky)};
        check("model", 32'(got), 32'(exp));
      end
    end
  endtask

  task automatic clear_counts();
    n_step = 0;
    n_wrap = 0;
    n_err  = 0;
  endtask

  task automatic do_reset();
    Clr = 1'b1;
    tick(2);
    check("reset_state", 32'({count_q, ext_count, valid, step_pulse, wrap_pulse, err_pulse,
                              err_sticky}), 32'(0));
    Clr = 1'b0;
    clear_counts();
  endtask

  initial begin
    #200_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int prev, v;

    vecs[0]  = '{4'hF, 10, 4'hF, 8'h0F, 1'b1, 0, 0, 0, 1'b0};
    vecs[1]  = '{4'hE, 6, 4'hE, 8'h0E, 1'b1, 1, 0, 0, 1'b0};
    vecs[2]  = '{4'hD, 6, 4'hD, 8'h0D, 1'b1, 1, 0, 0, 1'b0};
    vecs[3]  = '{4'hA, 6, 4'hA, 8'h0A, 1'b1, 1, 0, 0, 1'b0};
    vecs[4]  = '{4'h7, 6, 4'h7, 8'h07, 1'b1, 1, 0, 0, 1'b0};
    vecs[5]  = '{4'h4, 6, 4'h4, 8'h04, 1'b1, 1, 0, 0, 1'b0};
    vecs[6]  = '{4'h1, 6, 4'h1, 8'h01, 1'b1, 1, 0, 0, 1'b0};
    vecs[7]  = '{4'h0, 6, 4'h0, 8'h00, 1'b1, 1, 0, 0, 1'b0};
    vecs[8]  = '{4'hF, 6, 4'hF, 8'hFF, 1'b1, 1, 1, 0, 1'b0};
    vecs[9]  = '{4'hC, 6, 4'hC, 8'hFC, 1'b1, 1, 0, 0, 1'b0};
    vecs[10] = '{4'h9, 6, 4'h9, 8'hF9, 1'b1, 1, 0, 0, 1'b0};
    vecs[11] = '{4'h8, 6, 4'h8, 8'hF8, 1'b1, 1, 0, 0, 1'b0};
    vecs[12] = '{4'h0, 1, 4'h8, 8'hF8, 1'b1, 0, 0, 0, 1'b0};
    vecs[13] = '{4'h7, 6, 4'h7, 8'hF7, 1'b1, 1, 0, 0, 1'b0};
    vecs[14] = '{4'h4, 6, 4'h4, 8'hF4, 1'b1, 1, 0, 0, 1'b0};
    vecs[15] = '{4'h1, 6, 4'h1, 8'hF1, 1'b1, 1, 0, 0, 1'b0};
    vecs[16] = '{4'hF, 6, 4'hF, 8'hEF, 1'b1, 1, 1, 0, 1'b0};
    vecs[17] = '{4'hC, 6, 4'hC, 8'hEC, 1'b1, 1, 0, 0, 1'b0};
    vecs[18] = '{4'h9, 6, 4'h9, 8'hE9, 1'b1, 1, 0, 0, 1'b0};
    vecs[19] = '{4'h2, 6, 4'h9, 8'hE9, 1'b1, 0, 0, 1, 1'b1};
    vecs[20] = '{4'h5, 6, 4'h5, 8'h05, 1'b1, 0, 0, 0, 1'b1};
    vecs[21] = '{4'h4, 6, 4'h4, 8'h04, 1'b1, 1, 0, 0, 1'b1};

    Clr       = 1'b1;
    cnt_clr_n = 1'b1;
    count_in  = 4'h0;

    // First acceptance latency after reset.
    count_in = 4'hF;
    do_reset();
    for (int i = 1; i <= 5; i++) begin
      tick(1);
      check("latency_valid", 32'(valid), 32'(i == 5));
    end
    tick(5);
    check("latency_ext", 32'(ext_count), 32'h0F);
    check("latency_pulses", 32'(n_step + n_wrap + n_err), 32'(0));

    // Directed segment table.
    do_reset();
    for (int r = 0; r < 22; r++) begin
      count_in = vecs[r].val;
      clear_counts();
      tick(vecs[r].hold);
      check($sformatf("row%0d_count", r), 32'(count_q), 32'(vecs[r].cnt));
      check($sformatf("row%0d_ext", r), 32'(ext_count), 32'(vecs[r].ext));
      check($sformatf("row%0d_flags", r), 32'({valid, err_sticky}),
            32'({vecs[r].vld, vecs[r].sticky}));
      check($sformatf("row%0d_pulses", r), 32'((n_step << 16) | (n_wrap << 8) | n_err),
            32'((vecs[r].steps << 16) | (vecs[r].wraps << 8) | vecs[r].errs));
    end

    // Clr asserted while the filter window is partly elapsed.
    count_in = 4'h3;
    tick(2);
    Clr = 1'b1;
    tick(1);
    check("midfilter_clr", 32'({count_q, ext_count, valid, step_pulse, wrap_pulse, err_pulse,
                                err_sticky}), 32'(0));
    Clr = 1'b0;
    clear_counts();
    tick(7);
    check("after_clr_reacquire", 32'({ext_count, valid, err_sticky}), 32'({8'h03, 1'b1, 1'b0}));
    check("after_clr_pulses", 32'(n_step + n_wrap + n_err), 32'(0));

    // Counter clear while count_q=A.
    do_reset();
    count_in = 4'hA;
    tick(8);
    check("cntclr_pre", 32'({count_q, valid}), 32'({4'hA, 1'b1}));
    clear_counts();
    cnt_clr_n = 1'b0;
    count_in  = 4'h0;
    tick(3);
    check("cntclr_active", 32'({ext_count, valid}), 32'(0));
    cnt_clr_n = 1'b1;
    tick(1);
    check("cntclr_release", 32'({ext_count, valid}), 32'(0));
    tick(8);
    check("cntclr_reacquire", 32'({ext_count, valid, err_sticky}), 32'({8'h00, 1'b1, 1'b0}));
    check("cntclr_no_err", 32'(n_err), 32'(0));

    // Random bus activity against the reference model.
    do_reset();
    samples.delete();
    m_cnt    = 0;
    m_hi     = 0;
    m_valid  = 0;
    m_acq    = 0;
    m_sticky = 0;
    model_en = 1'b1;
    prev     = int'($urandom_range(15, 0));
    for (int s = 0; s < 150; s++) begin
      if ($urandom_range(9, 0) < 7) v = (prev - int'($urandom_range(4, 0))) & 15;
      else v = int'($urandom_range(15, 0));
      count_in = 4'(v);
      prev     = v;
      tick(int'($urandom_range(7, 1)));
    end
    model_en = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/ripple_count_monitor.md
Name: ripple_count_monitor

Overview:
- Clock-domain consumer for the 4-bit ripple down counter. It samples the counter's asynchronous, glitch-prone count bus and the counter's active-low clear level into the system clock domain.
- It filters out ripple transients and publishes a stable, validated count.
- It extends the count to a wider down count across 0->15 borrows, and flags illegal jumps.
- It sits directly downstream of the counter, between the counter and the system logic.

Parameters:
- STABLE_CYCLES, 2: consecutive Clk edges a synchronized value must hold before it is accepted. Legal range 1..15.
- MAX_STEP, 3: largest legal down-step (mod 16) between two accepted values. Legal range 1..15. Larger steps are errors.
- EXT_W, 8: width of the extended count, EXT_W >= 5. The low 4 bits are the filtered count.

Ports:
- Clk  in  1  system clock; all state updates on posedge.
- Clr  in  1  synchronous, active-high reset.
- count_in  in  4  raw counter output; asynchronous to Clk.
- cnt_clr_n  in  1  counter's ClrN level; asynchronous, active-low.
- count_q  out  4  filtered, accepted count.
- ext_count  out  EXT_W  extended down count; equals {hi, count_q}.
- valid  out  1  high once a first value has been accepted since reset or counter clear.
- step_pulse  out  1  one-cycle pulse on each accepted legal change.
- wrap_pulse  out  1  one-cycle pulse when an accepted change borrows through 0 (new > previous).
- err_pulse  out  1  one-cycle pulse on an illegal jump.
- err_sticky  out  1  latched error; cleared only by Clr.

Behaviour:
- One clock; reset is synchronous and active-high.
- Reset (Clr=1 at posedge) clears the following, overriding all other activity including mid-filter or mid-pulse operation:
  - sync flops, candidate and run counter;
  - count_q=0, ext_count=0, valid=0, all pulses=0, err_sticky=0;
  - state=S_INIT.
- Synchronizers: count_in (4 bits) and cnt_clr_n each pass through 2 flops (s1, s2).
  - The cnt_clr_n sync flops reset to 1.
- Stability filter:
  - cand <= s2 every cycle.
  - run resets to 0 when s2 != cand; otherwise run saturates upward.
  - A value is accepted when s2 == cand and run == STABLE_CYCLES-1.
- Latency: if count_in settles before edge k and holds, count_q updates at edge k+STABLE_CYCLES+2 (4 edges at default).
  - Any change inside the window restarts the filter.
- States:
  - S_INIT, waiting for the first accepted value:
    - On accept: count_q=value, ext_count={0,value}, valid=1.
    - No step, wrap or error pulses are produced.
    - Go to S_TRACK.
  - S_TRACK, on accept:
    - d = (count_q - value) mod 16.
    - d=0: no action.
    - 1 <= d <= MAX_STEP: count_q=value, step_pulse=1.
      - If value > old count_q, also wrap_pulse=1 and hi=hi-1 (mod 2^(EXT_W-4)); 0 wraps to all-ones.
    - d > MAX_STEP: err_pulse=1, err_sticky=1.
      - count_q and ext_count hold.
      - valid stays 1.
      - Go to S_INIT (re-acquire).
  - S_CLR, entered from any state when synchronized cnt_clr_n=0:
    - valid=0, count_q=0, ext_count=0, run=0.
    - No error is raised, since the clear jump is legal.
    - When cnt_clr_n returns to 1, go to S_INIT.
- Precedence when events coincide: Clr > cnt_clr_n low > accept.
- Pulses are exactly 1 cycle. At most one accept occurs per cycle.
- Outputs are registered; there are no combinational paths from inputs.

Decomposition:
- Shared package/header holds:
  - state encodings S_INIT, S_TRACK, S_CLR (2-bit);
  - count width constant CNT_W=4;
  - defaults for STABLE_CYCLES and MAX_STEP.
- One sub-module: sync_2ff (parameter WIDTH, reset value parameter), instantiated twice: 4-bit count, 1-bit clear.

Test Plan:
- Reset then count_in held at 4'hF for 10 cycles:
  - valid rises 4 edges after the first sampling edge;
  - count_q=F, ext_count=8'h0F, no pulses.
- Clean sequence F,E,D each held 6 cycles: 2 step_pulses; count_q=D; ext_count=8'h0D.
- Sequence 1,0,F:
  - at F: wrap_pulse=1, step_pulse=1;
  - ext_count 8'h00 -> 8'hFF.
- Glitch: at count_q=8, bus toggles 8->0->7 with 0 lasting 1 cycle: 0 is never accepted; one step to 7; no err_pulse.
- Illegal jump 9 -> 2 (d=7 > MAX_STEP=3):
  - err_pulse for 1 cycle, err_sticky=1, count_q holds 9;
  - next stable value is re-acquired without error;
  - err_sticky stays 1 until Clr.
- cnt_clr_n pulsed low 3 cycles while count_q=A and count_in goes to 0:
  - valid=0, ext_count=0, no error;
  - after release, count_q=0 is accepted, valid=1.
- Clr asserted mid-filter (window partly elapsed) clears everything at the next edge.
